rst_sequencer: RTL
==================

# rst_sequencer

Parametrised reset synchroniser and sequencer. Takes the board-level asynchronous reset and produces NUM_OUT active-high reset outputs. All outputs assert asynchronously and release synchronously to clk, staggered in a fixed order so downstream logic (video timing, game FSM, score logic, paddle/ball engines) comes out of reset deterministically. A synchronous soft-reset request re-runs the sequence without a board reset.

## Interface
- SYNC_STAGES, 2: flops in the deassertion synchroniser chain; legal range ≥ 2.
- NUM_OUT, 4: number of sequenced reset outputs; legal range ≥ 1.
- HOLD_CYCLES, 16: cycles all outputs stay asserted after the synchroniser releases; legal range ≥ 1.
- STEP_CYCLES, 8: cycles between consecutive output releases; legal range ≥ 1.
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-high; clock clk.
- soft_rst_req  input  1  synchronous single-cycle request to restart the sequence; level-sampled each edge.
- rst_out  output  NUM_OUT  active-high resets. Bit 0 releases first and bit NUM_OUT-1 releases last.
- seq_done  output  1  high once every rst_out bit is released.

## Operation
- **Synchroniser.** SYNC_STAGES flops, all asynchronously set by rst, shifting in 0. Its output is sync_rst.
- **FSM states:** ASSERT, HOLD, RELEASE, DONE. A counter of width $clog2(max(HOLD_CYCLES, STEP_CYCLES)+1) runs alongside, plus an index register of width $clog2(NUM_OUT+1).
- **rst high:** asynchronously forces
  - state = ASSERT, counter = 0, index = 0;
  - rst_out = all ones, seq_done = 0.
  These are also the reset values of every output.
- **ASSERT:** stays while sync_rst = 1. Moves to HOLD at the first edge where sync_rst samples 0; counter is cleared.
- **HOLD:** counter increments each edge. When counter reaches HOLD_CYCLES-1:
  - rst_out[0] clears on that edge;
  - state becomes RELEASE, counter = 0, index = 1.
  - If NUM_OUT = 1, the state goes straight to DONE and seq_done sets on the same edge.
- **RELEASE:** counter increments each edge. When counter reaches STEP_CYCLES-1:
  - rst_out[index] clears and index increments;
  - counter = 0.
  - The edge that clears rst_out[NUM_OUT-1] also moves the state to DONE and sets seq_done.
- **DONE:** holds until soft_rst_req or rst.
- **soft_rst_req = 1 in HOLD, RELEASE or DONE:** on that edge
  - rst_out = all ones, seq_done = 0;
  - state = HOLD, counter = 0, index = 0.
  This fully restarts the HOLD interval, including mid-sequence.
- **soft_rst_req in ASSERT:** ignored.
- **soft_rst_req on the same edge as a release step:** the soft request wins; no bit is released.
- **rst asserted mid-sequence or in DONE:** outputs reassert immediately with no clock needed, and the sequence restarts from ASSERT.
- rst_out bits only ever release in ascending index order. No bit releases before every lower bit has released.

## Timing
- Edge numbering: edge k is the k-th rising clk edge after rst deasserts, with setup met.
- sync_rst falls at edge SYNC_STAGES.
- HOLD is entered at edge SYNC_STAGES+1.
- rst_out[0] falls at edge SYNC_STAGES+HOLD_CYCLES+1.
- rst_out[i] falls at edge SYNC_STAGES+HOLD_CYCLES+1+i·STEP_CYCLES.
- seq_done rises on the same edge as rst_out[NUM_OUT-1].
- Defaults: rst_out[0..3] fall at edges 19, 27, 35, 43; seq_done rises at edge 43.
- soft_rst_req sampled at edge s: rst_out goes all ones at edge s, and rst_out[0] falls at edge s+HOLD_CYCLES.
- Assertion path from rst to rst_out is combinational-free: flop asynchronous set only, no clock dependency.
- All outputs are registered; there are no glitches on deassertion.

## Structure
- Shared package rst_seq_pkg:
  - state enum {ASSERT, HOLD, RELEASE, DONE};
  - default parameter constants.
- One sub-module, reset_sync_chain: parameter STAGES; ports clk, rst, sync_rst. It is reused elsewhere for single-channel reset synchronisation.
- The FSM, counter and index live in rst_sequencer.

## Test plan
- **Power-on, defaults:** pulse rst for 3 cycles, then release → rst_out = 4'b1111 through edge 18; 4'b1110 at edge 19, 4'b1100 at 27, 4'b1000 at 35, 4'b0000 at 43; seq_done = 1 from edge 43.
- **Async assert in DONE:** assert rst between clock edges → rst_out = 4'b1111 and seq_done = 0 before the next edge. On release, the full sequence repeats with identical edge numbers.
- **Soft reset in DONE:** assert soft_rst_req for one cycle at edge s → rst_out = 4'b1111 at s; 4'b1110 at s+16, 4'b1100 at s+24, 4'b1000 at s+32, 4'b0000 at s+40.
- **Soft reset mid-RELEASE:** assert soft_rst_req at the edge where rst_out[1] would release → rst_out returns to 4'b1111, no bit releases that edge, and HOLD restarts for 16 cycles.
- **Soft reset in ASSERT:** assert soft_rst_req during the synchroniser window → no effect; timing is identical to the power-on case.
- **Parameter sweep:** SYNC_STAGES=3, NUM_OUT=1, HOLD_CYCLES=1, STEP_CYCLES=1 → rst_out[0] and seq_done both change at edge 5. Also check that NUM_OUT=8 releases all bits in ascending order, one every STEP_CYCLES.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// State encoding, default parameters and a sizing helper.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } seq_state_e;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_NUM_OUT     = 4;
   localparam int DEF_HOLD_CYCLES = 16;
   localparam int DEF_STEP_CYCLES = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Soft-reset request and sequenced reset outputs of rst_sequencer.
// The sequencer drives the slave modport; its consumer uses master.
interface rst_sequencer_if
   import rst_seq_pkg::*;
#(
   parameter int NUM_OUT = DEF_NUM_OUT
);
   logic               soft_rst_req;
   logic [NUM_OUT-1:0] rst_out;
   logic               seq_done;

   modport master (output soft_rst_req, input rst_out, input seq_done);
   modport slave  (input soft_rst_req, output rst_out, output seq_done);
endinterface

// File: rtl/reset_sync_chain.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES clk edges.
// Also used standalone for single-channel reset synchronisation.
module reset_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   output logic sync_rst
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[STAGES-2:0], 1'b0};
   end

   assign sync_rst = sync_q[STAGES-1];
endmodule

// File: rtl/rst_sequencer.sv
// Staggered reset release: all outputs assert asynchronously with rst, then
// release one by one in ascending index order, synchronously to clk.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ASSERT  | waiting for the synchroniser to release; soft requests ignored
//   HOLD    | all outputs asserted, counting HOLD_CYCLES
//   RELEASE | releasing rst_out[idx] every STEP_CYCLES
//   DONE    | all outputs released, seq_done high
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int NUM_OUT     = DEF_NUM_OUT,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
   input  logic           clk,
   input  logic           rst,
   rst_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STEP_CYCLES) + 1);
   localparam int IDX_W = $clog2(NUM_OUT + 1);

   logic               sync_rst;
   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
   logic               done_q, done_d;
   logic               restart;

   reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .sync_rst (sync_rst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ASSERT;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         done_q    <= done_d;
      end
   end

   assign restart = bus.soft_rst_req && (state_q != ASSERT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      done_d    = done_q;

      unique case (state_q)
         ASSERT: begin
            if (!sync_rst) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               rst_out_d[0] = 1'b0;
               cnt_d        = '0;
               idx_d        = IDX_W'(1);
               if (NUM_OUT == 1) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
               rst_out_d = rst_out_q & ~(NUM_OUT'(1) << idx_q);
               idx_d     = idx_q + IDX_W'(1);
               cnt_d     = '0;
               if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
         end
         default: begin
            state_d = ASSERT;
         end
      endcase

      // A soft request overrides any release step on the same edge.
      if (restart) begin
         state_d   = HOLD;
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '1;
         done_d    = 1'b0;
      end
   end

   assign bus.rst_out  = rst_out_q;
   assign bus.seq_done = done_q;
endmodule
